// File: rtl/fb_scanout.sv
// Display scan-out: VGA-style timing generator that pulls framebuffer pixels in raster order
// and replicates each one SCALE x SCALE, using a single line buffer for the repeated rows.
module fb_scanout #(
    parameter int unsigned FB_WIDTH   = 128,
    parameter int unsigned FB_HEIGHT  = 128,
    parameter int unsigned SCALE      = 3,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter logic [11:0] BORDER_RGB = 12'h000
) (
    input  logic        clk_pix,
    input  logic        reset_i,
    output logic        stream_start_frame_o,
    output logic        stream_ena_o,
    input  logic [15:0] stream_data_i,
    input  logic        stream_err_underflow_i,
    output logic        err_underflow_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic [3:0]  r_o,
    output logic [3:0]  g_o,
    output logic [3:0]  b_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int unsigned FXW     = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
    localparam int unsigned WIN_W   = FB_WIDTH * SCALE;
    localparam int unsigned WIN_H   = FB_HEIGHT * SCALE;

    logic [HW-1:0]  hcnt_q, hcnt_d;
    logic [VW-1:0]  vcnt_q, vcnt_d;
    logic [SW-1:0]  sx_q, sx_d, sy_q, sy_d;
    logic [FXW-1:0] fx_q, fx_d;

    logic h_win_c, win_c, active_c, fetch_c, hs_c, vs_c;

    // Stage-1 (stream data / line-buffer read) and stage-2 (pins) state
    logic           act_p1_q, win_p1_q, frow_p1_q, ena_p1_q, hs_p1_q, vs_p1_q;
    logic [FXW-1:0] fx_p1_q;
    logic [11:0]    hold_q, lb_rd_q, colour_c;
    logic [11:0]    rgb_q;
    logic           de_q, hs_q, vs_q, err_q;
    logic [11:0]    lb_mem [FB_WIDTH];
    logic           unused_hi_c;

    assign unused_hi_c = ^stream_data_i[15:12];

    // Raster and sub-pixel counter next-state
    always_comb begin
        hcnt_d  = hcnt_q + HW'(1);
        vcnt_d  = vcnt_q;
        sx_d    = sx_q;
        fx_d    = fx_q;
        sy_d    = sy_q;
        h_win_c = hcnt_q < HW'(WIN_W);
        if (h_win_c) begin
            if (sx_q == SW'(SCALE - 1)) begin
                sx_d = '0;
                if (fx_q != FXW'(FB_WIDTH - 1)) fx_d = fx_q + FXW'(1);
            end else begin
                sx_d = sx_q + SW'(1);
            end
        end
        if (hcnt_q == HW'(H_TOTAL - 1)) begin
            hcnt_d = '0;
            sx_d   = '0;
            fx_d   = '0;
            if (vcnt_q == VW'(V_TOTAL - 1)) begin
                vcnt_d = '0;
                sy_d   = '0;
            end else begin
                vcnt_d = vcnt_q + VW'(1);
                sy_d   = (sy_q == SW'(SCALE - 1)) ? '0 : sy_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            sx_q   <= '0;
            fx_q   <= '0;
            sy_q   <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            sx_q   <= sx_d;
            fx_q   <= fx_d;
            sy_q   <= sy_d;
        end
    end

    assign active_c = (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
    assign win_c    = h_win_c && (vcnt_q < VW'(WIN_H));
    assign fetch_c  = win_c && (sy_q == '0) && (sx_q == '0);
    assign hs_c     = !((hcnt_q >= HW'(H_ACTIVE + H_FP)) && (hcnt_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_c     = !((vcnt_q >= VW'(V_ACTIVE + V_FP)) && (vcnt_q < VW'(V_ACTIVE + V_FP + V_SYNC)));

    assign stream_ena_o         = fetch_c && !reset_i;
    assign stream_start_frame_o = !reset_i && (hcnt_q == '0) && (vcnt_q == VW'(V_ACTIVE + V_FP));

    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            act_p1_q  <= 1'b0;
            win_p1_q  <= 1'b0;
            frow_p1_q <= 1'b0;
            ena_p1_q  <= 1'b0;
            hs_p1_q   <= 1'b1;
            vs_p1_q   <= 1'b1;
            fx_p1_q   <= '0;
            hold_q    <= '0;
        end else begin
            act_p1_q  <= active_c;
            win_p1_q  <= win_c;
            frow_p1_q <= (sy_q == '0);
            ena_p1_q  <= fetch_c;
            hs_p1_q   <= hs_c;
            vs_p1_q   <= vs_c;
            fx_p1_q   <= fx_q;
            if (ena_p1_q) hold_q <= stream_data_i[11:0];
        end
    end

    // Line buffer: written on fetch rows, synchronously read on repeat rows
    always_ff @(posedge clk_pix) begin
        if (ena_p1_q) lb_mem[fx_p1_q] <= stream_data_i[11:0];
        lb_rd_q <= lb_mem[fx_q];
    end

    always_comb begin
        colour_c = '0;
        if (act_p1_q) begin
            if (!win_p1_q)      colour_c = BORDER_RGB;
            else if (ena_p1_q)  colour_c = stream_data_i[11:0];
            else if (frow_p1_q) colour_c = hold_q;
            else                colour_c = lb_rd_q;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            err_q <= 1'b0;
        end else begin
            rgb_q <= colour_c;
            de_q  <= act_p1_q;
            hs_q  <= hs_p1_q;
            vs_q  <= vs_p1_q;
            err_q <= err_q | stream_err_underflow_i;
        end
    end

    assign r_o             = rgb_q[11:8];
    assign g_o             = rgb_q[7:4];
    assign b_o             = rgb_q[3:0];
    assign de_o            = de_q;
    assign hsync_o         = hs_q;
    assign vsync_o         = vs_q;
    assign err_underflow_o = err_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: a small SCALE=3 raster, a SCALE=1 raster and the default
// 640x480 timing run side by side against a cycle model of the display timing.
module tb_fb_scanout;

    localparam int A_FBW = 4, A_FBH = 3, A_S = 3;
    localparam int A_HA = 16, A_HFP = 2, A_HS = 3, A_HBP = 2;
    localparam int A_VA = 12, A_VFP = 1, A_VS = 2, A_VBP = 1;
    localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
    localparam int A_VT = A_VA + A_VFP + A_VS + A_VBP;
    localparam logic [11:0] A_BORD = 12'h5A5;

    localparam int B_FBW = 6, B_FBH = 2, B_S = 1;
    localparam int B_HA = 6, B_HFP = 1, B_HS = 2, B_HBP = 1;
    localparam int B_VA = 2, B_VFP = 1, B_VS = 1, B_VBP = 1;
    localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
    localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;

    localparam int C_FBW = 128, C_FBH = 128, C_S = 3;
    localparam int C_HA = 640, C_HFP = 16, C_HS = 96, C_HBP = 48;
    localparam int C_VA = 480, C_VFP = 10, C_VS = 2, C_VBP = 33;
    localparam int C_HT = 800, C_VT = 525;

    typedef struct packed {
        logic        ena;
        logic        sf;
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] rgb;
    } exp_t;

    localparam exp_t RST_E = '{ena: 1'b0, sf: 1'b0, hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 12'h000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uf  = 1'b0;
    logic mon_en = 1'b0;

    logic        a_sf, a_ena, a_err, a_hs, a_vs, a_de;
    logic [3:0]  a_r, a_g, a_b;
    logic [15:0] a_data = 16'h0, a_k = 16'h0;
    logic        b_sf, b_ena, b_err, b_hs, b_vs, b_de;
    logic [3:0]  b_r, b_g, b_b;
    logic [15:0] b_data = 16'h0, b_k = 16'h0;
    logic        c_sf, c_ena, c_err, c_hs, c_vs, c_de;
    logic [3:0]  c_r, c_g, c_b;
    logic [15:0] c_data = 16'h0, c_k = 16'h0;

    int   total = 0;
    int   bad   = 0;
    int   a_h, a_v, b_h, b_v, c_h, c_v, c_cnt;
    exp_t a_hist [2];
    exp_t b_hist [2];
    exp_t c_hist [2];

    always #5 clk = ~clk;

    fb_scanout #(
        .FB_WIDTH(A_FBW), .FB_HEIGHT(A_FBH), .SCALE(A_S),
        .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
        .BORDER_RGB(A_BORD)
    ) u_a (
        .clk_pix(clk), .reset_i(rst), .stream_start_frame_o(a_sf), .stream_ena_o(a_ena),
        .stream_data_i(a_data), .stream_err_underflow_i(uf), .err_underflow_o(a_err),
        .hsync_o(a_hs), .vsync_o(a_vs), .de_o(a_de), .r_o(a_r), .g_o(a_g), .b_o(a_b)
    );

    fb_scanout #(
        .FB_WIDTH(B_FBW), .FB_HEIGHT(B_FBH), .SCALE(B_S),
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .BORDER_RGB(12'h000)
    ) u_b (
        .clk_pix(clk), .reset_i(rst), .stream_start_frame_o(b_sf), .stream_ena_o(b_ena),
        .stream_data_i(b_data), .stream_err_underflow_i(uf), .err_underflow_o(b_err),
        .hsync_o(b_hs), .vsync_o(b_vs), .de_o(b_de), .r_o(b_r), .g_o(b_g), .b_o(b_b)
    );

    fb_scanout u_c (
        .clk_pix(clk), .reset_i(rst), .stream_start_frame_o(c_sf), .stream_ena_o(c_ena),
        .stream_data_i(c_data), .stream_err_underflow_i(uf), .err_underflow_o(c_err),
        .hsync_o(c_hs), .vsync_o(c_vs), .de_o(c_de), .r_o(c_r), .g_o(c_g), .b_o(c_b)
    );

    // Framebuffer stream models: pixel index k returned as 16'hFkkk the cycle after a request
    always @(posedge clk) begin
        if (rst || a_sf) a_k <= 16'h0;
        else if (a_ena) begin a_data <= {4'hF, a_k[11:0]}; a_k <= a_k + 16'd1; end
        if (rst || b_sf) b_k <= 16'h0;
        else if (b_ena) begin b_data <= {4'hF, b_k[11:0]}; b_k <= b_k + 16'd1; end
        if (rst || c_sf) c_k <= 16'h0;
        else if (c_ena) begin c_data <= {4'hF, c_k[11:0]}; c_k <= c_k + 16'd1; end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic exp_t model(input int h, input int v, input int fbw, input int fbh,
                                   input int s, input int ha, input int hfp, input int hsy,
                                   input int va, input int vfp, input int vsy,
                                   input logic [11:0] bord);
        exp_t e;
        int   idx;
        bit   act, win;
        act   = (h < ha) && (v < va);
        win   = (h < fbw * s) && (v < fbh * s);
        idx   = (v / s) * fbw + h / s;
        e.ena = win && (v % s == 0) && (h % s == 0);
        e.sf  = (h == 0) && (v == va + vfp);
        e.hs  = !((h >= ha + hfp) && (h < ha + hfp + hsy));
        e.vs  = !((v >= va + vfp) && (v < va + vfp + vsy));
        e.de  = act;
        e.rgb = !act ? 12'h000 : (win ? 12'(idx) : bord);
        return e;
    endfunction

    task automatic step(inout int h, inout int v, input int ht, input int vt);
        h++;
        if (h == ht) begin
            h = 0;
            v = (v == vt - 1) ? 0 : v + 1;
        end
    endtask

    // Per-cycle compare: request/start decode now, pins against the model two cycles back
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            e = model(a_h, a_v, A_FBW, A_FBH, A_S, A_HA, A_HFP, A_HS, A_VA, A_VFP, A_VS, A_BORD);
            check_eq("a_ena", a_ena, e.ena);
            check_eq("a_sf", a_sf, e.sf);
            check_eq("a_hsync", a_hs, a_hist[1].hs);
            check_eq("a_vsync", a_vs, a_hist[1].vs);
            check_eq("a_de", a_de, a_hist[1].de);
            check_eq("a_rgb", {a_r, a_g, a_b}, a_hist[1].rgb);
            a_hist[1] = a_hist[0];
            a_hist[0] = e;
            step(a_h, a_v, A_HT, A_VT);

            e = model(b_h, b_v, B_FBW, B_FBH, B_S, B_HA, B_HFP, B_HS, B_VA, B_VFP, B_VS, 12'h000);
            check_eq("b_ena", b_ena, e.ena);
            check_eq("b_sf", b_sf, e.sf);
            check_eq("b_de", b_de, b_hist[1].de);
            check_eq("b_hsync", b_hs, b_hist[1].hs);
            check_eq("b_rgb", {b_r, b_g, b_b}, b_hist[1].rgb);
            b_hist[1] = b_hist[0];
            b_hist[0] = e;
            step(b_h, b_v, B_HT, B_VT);

            e = model(c_h, c_v, C_FBW, C_FBH, C_S, C_HA, C_HFP, C_HS, C_VA, C_VFP, C_VS, 12'h000);
            check_eq("c_ena", c_ena, e.ena);
            check_eq("c_hsync", c_hs, c_hist[1].hs);
            check_eq("c_vsync", c_vs, c_hist[1].vs);
            check_eq("c_de", c_de, c_hist[1].de);
            check_eq("c_rgb", {c_r, c_g, c_b}, c_hist[1].rgb);
            if (c_ena) c_cnt++;
            if (c_h == C_HT - 1) begin
                check_eq("c_line_reqs", c_cnt, ((c_v % 3 == 0) && (c_v < 384)) ? 128 : 0);
                c_cnt = 0;
            end
            c_hist[1] = c_hist[0];
            c_hist[0] = e;
            step(c_h, c_v, C_HT, C_VT);
        end
    end

    task automatic do_reset(input logic with_uf);
        @(negedge clk);
        mon_en = 1'b0;
        rst    = 1'b1;
        uf     = with_uf;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_a_hsync", a_hs, 1);
        check_eq("rst_a_vsync", a_vs, 1);
        check_eq("rst_a_de", a_de, 0);
        check_eq("rst_a_rgb", {a_r, a_g, a_b}, 0);
        check_eq("rst_a_ena", a_ena, 0);
        check_eq("rst_a_sf", a_sf, 0);
        check_eq("rst_c_hsync", c_hs, 1);
        check_eq("rst_c_ena", c_ena, 0);
        check_eq("rst_a_err", a_err, 0);
        check_eq("rst_c_err", c_err, 0);
        rst = 1'b0;
        uf  = 1'b0;
        #1;
        check_eq("first_ena_a", a_ena, 1);
        check_eq("first_ena_b", b_ena, 1);
        check_eq("first_ena_c", c_ena, 1);
        a_hist[1] = RST_E;
        a_hist[0] = model(0, 0, A_FBW, A_FBH, A_S, A_HA, A_HFP, A_HS, A_VA, A_VFP, A_VS, A_BORD);
        b_hist[1] = RST_E;
        b_hist[0] = model(0, 0, B_FBW, B_FBH, B_S, B_HA, B_HFP, B_HS, B_VA, B_VFP, B_VS, 12'h000);
        c_hist[1] = RST_E;
        c_hist[0] = model(0, 0, C_FBW, C_FBH, C_S, C_HA, C_HFP, C_HS, C_VA, C_VFP, C_VS, 12'h000);
        a_h = 1; a_v = 0;
        b_h = 1; b_v = 0;
        c_h = 1; c_v = 0;
        c_cnt  = 1;
        mon_en = 1'b1;
    endtask

    initial begin
        do_reset(1'b0);
        repeat (200) @(negedge clk);
        check_eq("err_idle_a", a_err, 0);
        uf = 1'b1;
        @(negedge clk);
        uf = 1'b0;
        check_eq("err_set_a", a_err, 1);
        check_eq("err_set_b", b_err, 1);
        check_eq("err_set_c", c_err, 1);
        repeat (3000) @(negedge clk);
        check_eq("err_held_a", a_err, 1);
        check_eq("err_held_c", c_err, 1);
        // Reset lands mid-frame with underflow asserted alongside it
        do_reset(1'b1);
        check_eq("err_clear_a", a_err, 0);
        repeat (800) @(negedge clk);
        check_eq("err_stay_clear_b", b_err, 0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
